// File: rtl/freq_multi_check_if.sv
// Bus bundle for freq_multi_check: counter state, result RAM readout,
// limit programming, alarm clear and per-channel status outputs.
interface freq_multi_check_if #(
    parameter int NCH = 8,
    parameter int AW  = 3,
    parameter int cw  = 3,
    parameter int uw  = 28
) ();

    logic [AW+cw-1:0] source_state;
    logic [AW-1:0]    addr;
    logic [uw-1:0]    frequency;
    logic             lim_we;
    logic [AW:0]      lim_addr;
    logic [uw-1:0]    lim_data;
    logic             clr;
    logic [NCH-1:0]   valid;
    logic [NCH-1:0]   in_range;
    logic [NCH-1:0]   alarm;
    logic             scan_done;
    logic [7:0]       scan_count;

    // Environment side: owns the counter, RAM and limit programming.
    modport master (
        output source_state,
        output frequency,
        output lim_we,
        output lim_addr,
        output lim_data,
        output clr,
        input  addr,
        input  valid,
        input  in_range,
        input  alarm,
        input  scan_done,
        input  scan_count
    );

    // Checker side.
    modport slave (
        input  source_state,
        input  frequency,
        input  lim_we,
        input  lim_addr,
        input  lim_data,
        input  clr,
        output addr,
        output valid,
        output in_range,
        output alarm,
        output scan_done,
        output scan_count
    );

endinterface

// File: rtl/freq_multi_check.sv
// Multi-channel frequency window checker. Each time the counter state
// changes, every channel's result is read from the counter RAM (one cycle
// of read latency) and compared against its programmable lo/hi window.
// A channel's result is only trusted once the counter has moved on from
// acquiring it at least once since reset.
module freq_multi_check #(
    parameter int NCH = 8,
    parameter int AW  = 3,
    parameter int cw  = 3,
    parameter int uw  = 28
) (
    input  logic                 refclk,
    input  logic                 rst,
    freq_multi_check_if.slave    bus
);

    localparam int            SW      = AW + cw;
    localparam logic [AW-1:0] LAST_CH = AW'(NCH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SET  = 3'd1,
        WAIT = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Unsigned window test; an inverted window (lo > hi) can never pass.
    function automatic logic out_of_range(input logic [uw-1:0] f,
                                          input logic [uw-1:0] lo,
                                          input logic [uw-1:0] hi);
        return (f < lo) || (f > hi);
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   ch_r;
    logic [AW-1:0]   ch_nxt_s;

    logic [SW-1:0]   src_r;
    logic [SW-1:0]   src_prev_r;
    logic            change_s;
    logic            pending_r;
    logic            pending_nxt_s;

    logic [uw-1:0]   lo_r [NCH];
    logic [uw-1:0]   hi_r [NCH];

    logic [NCH-1:0]  valid_r;
    logic [NCH-1:0]  valid_nxt_s;
    logic [NCH-1:0]  in_range_r;
    logic [NCH-1:0]  in_range_nxt_s;
    logic [NCH-1:0]  alarm_r;
    logic [NCH-1:0]  alarm_nxt_s;
    logic            out_s;
    logic            last_cmp_s;
    logic            scan_done_r;
    logic [7:0]      scan_count_r;

    // Capture the counter state and keep the previous capture for change detection.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            src_r      <= '0;
            src_prev_r <= '0;
        end else begin
            src_r      <= bus.source_state;
            src_prev_r <= src_r;
        end
    end

    assign change_s   = (src_r != src_prev_r);
    assign out_s      = out_of_range(bus.frequency, lo_r[ch_r], hi_r[ch_r]);
    assign last_cmp_s = (state_r == CMP) && (ch_r == LAST_CH);

    // A channel becomes trustworthy once acquisition has moved away from it.
    always_comb begin
        valid_nxt_s = valid_r;
        if (src_r[AW-1:0] != src_prev_r[AW-1:0]) begin
            valid_nxt_s[src_prev_r[AW-1:0]] = 1'b1;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // Scan sequencer: next state and channel index.
    always_comb begin
        state_nxt_s = state_r;
        ch_nxt_s    = ch_r;
        case (state_r)
            IDLE: begin
                if (change_s || pending_r) begin
                    state_nxt_s = SET;
                    ch_nxt_s    = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SET:  state_nxt_s = WAIT;
            WAIT: state_nxt_s = CMP;
            CMP: begin
                if (ch_r == LAST_CH) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SET;
                    ch_nxt_s    = ch_r + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: begin
                state_nxt_s = IDLE;
                ch_nxt_s    = '0;
            end
        endcase
    end

    // Changes seen mid-scan collapse into one pending rescan; IDLE consumes it.
    always_comb begin
        pending_nxt_s = pending_r;
        if (state_r == IDLE) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r | change_s;
        end
    end

    // Compare result and sticky alarm update; a fresh alarm outranks clr.
    always_comb begin
        in_range_nxt_s = in_range_r;
        alarm_nxt_s    = alarm_r;
        if (bus.clr) begin
            alarm_nxt_s = '0;
        end else begin
            alarm_nxt_s = alarm_r;
        end
        if ((state_r == CMP) && valid_r[ch_r]) begin
            in_range_nxt_s[ch_r] = ~out_s;
            alarm_nxt_s[ch_r]    = alarm_nxt_s[ch_r] | out_s;
        end else begin
            in_range_nxt_s = in_range_r;
        end
    end

    // Sequencer state, channel index (which is also the RAM address) and pending flag.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ch_r      <= '0;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ch_r      <= ch_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    // Per-channel window limits; writes land on the next edge in any state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                lo_r[i] <= '0;
                hi_r[i] <= '1;
            end
        end else if (bus.lim_we) begin
            if (bus.lim_addr[0]) begin
                hi_r[bus.lim_addr[AW:1]] <= bus.lim_data;
            end else begin
                lo_r[bus.lim_addr[AW:1]] <= bus.lim_data;
            end
        end
    end

    // Status flags, end-of-scan pulse and scan counter.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            valid_r      <= '0;
            in_range_r   <= '0;
            alarm_r      <= '0;
            scan_done_r  <= 1'b0;
            scan_count_r <= 8'd0;
        end else begin
            valid_r      <= valid_nxt_s;
            in_range_r   <= in_range_nxt_s;
            alarm_r      <= alarm_nxt_s;
            scan_done_r  <= last_cmp_s;
            if (last_cmp_s) begin
                scan_count_r <= scan_count_r + 8'd1;
            end
        end
    end

    assign bus.addr       = ch_r;
    assign bus.valid      = valid_r;
    assign bus.in_range   = in_range_r;
    assign bus.alarm      = alarm_r;
    assign bus.scan_done  = scan_done_r;
    assign bus.scan_count = scan_count_r;

endmodule

// File: tb/tb_freq_multi_check.sv
// Directed bench for freq_multi_check with a scan-result scoreboard.
module tb_freq_multi_check;

    localparam int NCH = 8;
    localparam int AW  = 3;
    localparam int CW  = 3;
    localparam int UW  = 28;

    logic refclk = 1'b0;
    logic rst;

    always #5 refclk = ~refclk;

    freq_multi_check_if #(.NCH(NCH), .AW(AW), .cw(CW), .uw(UW)) bus ();

    freq_multi_check #(.NCH(NCH), .AW(AW), .cw(CW), .uw(UW)) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    // Synchronous result RAM: data follows addr by one clock.
    logic [UW-1:0] ram [NCH];
    always @(posedge refclk) bus.frequency <= ram[bus.addr];

    typedef struct {
        logic [7:0] cnt;
        logic [7:0] vld;
        logic [7:0] inr;
        logic [7:0] alm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] cnt, input logic [7:0] vld,
                            input logic [7:0] inr, input logic [7:0] alm);
        exp_t e;
        e.cnt = cnt; e.vld = vld; e.inr = inr; e.alm = alm;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; holds the write across exactly one rising edge.
    task automatic lim_write(input int ch, input logic sel_hi, input logic [UW-1:0] val);
        bus.lim_we   = 1'b1;
        bus.lim_addr = {3'(ch), sel_hi};
        bus.lim_data = val;
        @(negedge refclk);
        bus.lim_we   = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge refclk);
            cyc++;
            if (bus.scan_done === 1'b1) return;
        end
        total++;
        bad++;
        $display("FAIL scan_timeout: got no scan_done in %0d cycles, expected one", cyc);
    endtask

    // Monitor: every scan_done pulse must match the oldest expected scan result.
    always @(negedge refclk) begin
        if (rst === 1'b0 && bus.scan_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_scan_done: got pulse with scan_count=%0d, expected none",
                         bus.scan_count);
            end else begin
                mon_e = exp_q.pop_front();
                chk("scan_count", bus.scan_count, mon_e.cnt);
                chk("valid",      bus.valid,      mon_e.vld);
                chk("in_range",   bus.in_range,   mon_e.inr);
                chk("alarm",      bus.alarm,      mon_e.alm);
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.source_state = '0;
        bus.lim_we       = 1'b0;
        bus.lim_addr     = '0;
        bus.lim_data     = '0;
        bus.clr          = 1'b0;
        for (int i = 0; i < NCH; i++) ram[i] = 28'd100;

        repeat (3) @(negedge refclk);
        rst = 1'b0;
        @(negedge refclk);
        chk("rst_valid",      bus.valid,      32'h0);
        chk("rst_in_range",   bus.in_range,   32'h0);
        chk("rst_alarm",      bus.alarm,      32'h0);
        chk("rst_scan_done",  bus.scan_done,  32'h0);
        chk("rst_scan_count", bus.scan_count, 32'h0);
        chk("rst_addr",       bus.addr,       32'h0);

        // First change 0->1: channel 0 becomes valid, scan completes 25 cycles later.
        push_exp(8'd1, 8'h01, 8'h01, 8'h00);
        bus.source_state = 6'd1;
        wait_done(n);
        chk("scan_latency", n - 1, 32'd25);

        // Channel 2 window 1000..2000.
        lim_write(2, 1'b0, 28'd1000);
        lim_write(2, 1'b1, 28'd2000);
        ram[2] = 28'd2500;
        push_exp(8'd2, 8'h03, 8'h03, 8'h00);
        bus.source_state = 6'd2;
        wait_done(n);
        push_exp(8'd3, 8'h07, 8'h03, 8'h04);
        bus.source_state = 6'd3;
        wait_done(n);
        ram[2] = 28'd1500;
        push_exp(8'd4, 8'h0F, 8'h0F, 8'h04);
        bus.source_state = 6'd4;
        wait_done(n);
        bus.clr = 1'b1;
        @(negedge refclk);
        bus.clr = 1'b0;
        chk("clr_alarm", bus.alarm, 32'h0);

        push_exp(8'd5, 8'h1F, 8'h1F, 8'h00);
        bus.source_state = 6'd5;
        wait_done(n);
        push_exp(8'd6, 8'h3F, 8'h3F, 8'h00);
        bus.source_state = 6'd6;
        wait_done(n);

        // ch1 and ch5 out of range; clr lands in ch5's compare cycle.
        lim_write(1, 1'b1, 28'd50);
        lim_write(5, 1'b1, 28'd50);
        push_exp(8'd7, 8'h7F, 8'h5D, 8'h20);
        bus.source_state = 6'd7;
        repeat (19) @(negedge refclk);
        bus.clr = 1'b1;
        @(negedge refclk);
        bus.clr = 1'b0;
        wait_done(n);

        lim_write(1, 1'b1, 28'hFFFFFFF);
        lim_write(5, 1'b1, 28'hFFFFFFF);
        bus.clr = 1'b1;
        @(negedge refclk);
        bus.clr = 1'b0;

        // Three changes during one scan yield exactly one extra scan.
        push_exp(8'd8, 8'hFF, 8'hFF, 8'h00);
        push_exp(8'd9, 8'hFF, 8'hFF, 8'h00);
        bus.source_state = 6'd0;
        repeat (4) @(negedge refclk);
        bus.source_state = 6'd1;
        repeat (4) @(negedge refclk);
        bus.source_state = 6'd2;
        repeat (4) @(negedge refclk);
        bus.source_state = 6'd3;
        wait_done(n);
        wait_done(n);
        repeat (40) @(negedge refclk);
        chk("no_extra_scan", bus.scan_count, 32'd9);

        // Inverted window on ch0: always out of range.
        lim_write(0, 1'b0, 28'd5);
        lim_write(0, 1'b1, 28'd4);
        push_exp(8'd10, 8'hFF, 8'hFE, 8'h01);
        bus.source_state = 6'd4;
        wait_done(n);

        // Reset while channel 3 is being processed.
        bus.source_state = 6'd5;
        repeat (11) @(negedge refclk);
        rst = 1'b1;
        bus.source_state = 6'd0;
        #1;
        chk("mid_rst_valid",      bus.valid,      32'h0);
        chk("mid_rst_in_range",   bus.in_range,   32'h0);
        chk("mid_rst_alarm",      bus.alarm,      32'h0);
        chk("mid_rst_scan_done",  bus.scan_done,  32'h0);
        chk("mid_rst_scan_count", bus.scan_count, 32'h0);
        chk("mid_rst_addr",       bus.addr,       32'h0);
        repeat (3) @(negedge refclk);
        rst = 1'b0;
        repeat (40) @(negedge refclk);
        chk("post_rst_scan_count", bus.scan_count, 32'h0);

        // Fresh scan after reset; limits are back to full range.
        push_exp(8'd1, 8'h01, 8'h01, 8'h00);
        bus.source_state = 6'd6;
        wait_done(n);
        chk("post_rst_latency", n - 1, 32'd25);

        repeat (2) @(negedge refclk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
